// File: rtl/crossy_lane_engine.sv
// Crossy Road game core: obstacle lanes, vertical scroll, score, lives and the
// idle/play/hit/over state machine, with a registered per-pixel colour output.
module crossy_lane_engine #(
   parameter int unsigned N_LANES      = 4,
   parameter int unsigned OB_W         = 50,
   parameter int unsigned OB_H         = 30,
   parameter int unsigned CHK_X        = 310,
   parameter int unsigned CHK_Y        = 400,
   parameter int unsigned CHK_W        = 30,
   parameter int unsigned CHK_H        = 40,
   parameter int unsigned LANE_PITCH   = 120,
   parameter int unsigned OB_X_SPACING = 250,
   parameter int unsigned SCROLL_STEP  = 10,
   parameter int unsigned LIVES        = 3,
   parameter int unsigned FLASH_FRAMES = 60
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [9:0] i_hpos,
   input  logic [9:0] i_vpos,
   input  logic       i_display_on,
   input  logic       i_frame_tick,
   input  logic       i_move_btn,
   input  logic       i_start_btn,
   output logic [2:0] o_rgb,
   output logic [7:0] o_score,
   output logic [1:0] o_lives,
   output logic [1:0] o_state,
   output logic       o_collision
);

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;
   // Flash counter is at least 4 bits wide so bit 3 always exists for the blink.
   localparam int unsigned FLASH_W  = ($clog2(FLASH_FRAMES) > 4) ? $clog2(FLASH_FRAMES) : 4;

   localparam logic [10:0] CHK_X0 = 11'(CHK_X);
   localparam logic [10:0] CHK_X1 = 11'(CHK_X + CHK_W);
   localparam logic [10:0] CHK_Y0 = 11'(CHK_Y);
   localparam logic [10:0] CHK_Y1 = 11'(CHK_Y + CHK_H);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_HIT  = 2'b10,
      ST_OVER = 2'b11
   } state_t;

   function automatic logic [9:0] lane_x0(input int unsigned idx);
      return 10'((idx * OB_X_SPACING) % SCREEN_W);
   endfunction

   function automatic logic [8:0] lane_y0(input int unsigned idx);
      return 9'((idx * LANE_PITCH) % SCREEN_H);
   endfunction

   // One frame of horizontal motion: even lanes move right, odd lanes left, both wrap.
   function automatic logic [9:0] lane_step(input int unsigned idx, input logic [9:0] x);
      logic [10:0] spd;
      logic [10:0] fwd;
      spd = 11'((idx % 3) + 1);
      fwd = 11'(x) + spd;
      if ((idx % 2) == 0) begin
         return (fwd >= 11'(SCREEN_W)) ? 10'(fwd - 11'(SCREEN_W)) : 10'(fwd);
      end
      return (11'(x) < spd) ? 10'(11'(x) + 11'(SCREEN_W) - spd) : 10'(11'(x) - spd);
   endfunction

   function automatic logic [8:0] scroll_add(input logic [8:0] s);
      logic [10:0] sum;
      sum = 11'(s) + 11'(SCROLL_STEP);
      return (sum >= 11'(SCREEN_H)) ? 9'(sum - 11'(SCREEN_H)) : 9'(sum);
   endfunction

   state_t             state_q, state_d;
   logic [7:0]         score_q, score_d;
   logic [1:0]         lives_q, lives_d;
   logic [8:0]         scroll_q, scroll_d;
   logic [9:0]         lane_x_q [N_LANES];
   logic [9:0]         lane_x_d [N_LANES];
   logic [FLASH_W-1:0] flash_q, flash_d;
   logic               hit_q, hit_d;
   logic               coll_q, coll_d;
   logic [2:0]         rgb_q, rgb_d;
   logic [2:0]         move_sync_q, start_sync_q;

   logic               move_edge, start_edge;
   logic [10:0]        hpos_w, vpos_w;
   logic [10:0]        y_sum  [N_LANES];
   logic [10:0]        lane_y [N_LANES];
   logic [N_LANES-1:0] ob_hit;
   logic               any_ob, chk, chk_vis;

   assign move_edge  = move_sync_q[1]  & ~move_sync_q[2];
   assign start_edge = start_sync_q[1] & ~start_sync_q[2];
   assign hpos_w     = {1'b0, i_hpos};
   assign vpos_w     = {1'b0, i_vpos};

   // Per-pixel obstacle coverage; rectangles clip at the screen edge.
   always_comb begin
      for (int unsigned i = 0; i < N_LANES; i++) begin
         y_sum[i]  = 11'(lane_y0(i)) + 11'(scroll_q);
         lane_y[i] = (y_sum[i] >= 11'(SCREEN_H)) ? y_sum[i] - 11'(SCREEN_H) : y_sum[i];
         ob_hit[i] = (hpos_w >= {1'b0, lane_x_q[i]}) &&
                     (hpos_w <  {1'b0, lane_x_q[i]} + 11'(OB_W)) &&
                     (vpos_w >= lane_y[i]) &&
                     (vpos_w <  lane_y[i] + 11'(OB_H));
      end
   end

   assign any_ob  = |ob_hit;
   assign chk     = (hpos_w >= CHK_X0) && (hpos_w < CHK_X1) &&
                    (vpos_w >= CHK_Y0) && (vpos_w < CHK_Y1);
   assign chk_vis = !((state_q == ST_HIT) && flash_q[3]);

   // Pixel colour priority.
   always_comb begin
      rgb_d = 3'b000;
      if (!i_display_on)          rgb_d = 3'b000;
      else if (chk && any_ob)     rgb_d = 3'b011;
      else if (any_ob)            rgb_d = 3'b100;
      else if (chk && chk_vis)    rgb_d = 3'b010;
      else if (state_q == ST_OVER) rgb_d = 3'b000;
      else                        rgb_d = 3'b001;
   end

   // Game state machine and all game-state next values.
   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      lives_d  = lives_q;
      scroll_d = scroll_q;
      flash_d  = flash_q;
      hit_d    = hit_q;
      coll_d   = 1'b0;
      for (int unsigned i = 0; i < N_LANES; i++) lane_x_d[i] = lane_x_q[i];

      // The latch is sampled by the FSM below before this frame_tick clears it.
      if (i_frame_tick)
         hit_d = 1'b0;
      else if ((state_q == ST_PLAY) && i_display_on && chk && any_ob)
         hit_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d  = ST_PLAY;
               score_d  = 8'd0;
               lives_d  = 2'(LIVES);
               scroll_d = 9'd0;
               for (int unsigned i = 0; i < N_LANES; i++) lane_x_d[i] = lane_x0(i);
            end
         end
         ST_PLAY: begin
            if (move_edge) begin
               scroll_d = scroll_add(scroll_q);
               if (score_q != 8'hFF) score_d = score_q + 8'd1;
            end
            if (i_frame_tick) begin
               for (int unsigned i = 0; i < N_LANES; i++) lane_x_d[i] = lane_step(i, lane_x_q[i]);
               if (hit_q) begin
                  state_d = ST_HIT;
                  lives_d = lives_q - 2'd1;
                  coll_d  = 1'b1;
                  flash_d = '0;
               end
            end
         end
         ST_HIT: begin
            if (i_frame_tick) begin
               if (flash_q == FLASH_W'(FLASH_FRAMES - 1)) begin
                  if (lives_q == 2'd0) begin
                     state_d = ST_OVER;
                  end else begin
                     state_d  = ST_PLAY;
                     scroll_d = 9'd0;
                     for (int unsigned i = 0; i < N_LANES; i++) lane_x_d[i] = lane_x0(i);
                  end
               end else begin
                  flash_d = flash_q + FLASH_W'(1);
               end
            end
         end
         ST_OVER: begin
            if (start_edge) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         score_q      <= 8'd0;
         lives_q      <= 2'(LIVES);
         scroll_q     <= 9'd0;
         flash_q      <= '0;
         hit_q        <= 1'b0;
         coll_q       <= 1'b0;
         rgb_q        <= 3'b000;
         move_sync_q  <= 3'b000;
         start_sync_q <= 3'b000;
         for (int unsigned i = 0; i < N_LANES; i++) lane_x_q[i] <= lane_x0(i);
      end else begin
         state_q      <= state_d;
         score_q      <= score_d;
         lives_q      <= lives_d;
         scroll_q     <= scroll_d;
         flash_q      <= flash_d;
         hit_q        <= hit_d;
         coll_q       <= coll_d;
         rgb_q        <= rgb_d;
         move_sync_q  <= {move_sync_q[1:0], i_move_btn};
         start_sync_q <= {start_sync_q[1:0], i_start_btn};
         for (int unsigned i = 0; i < N_LANES; i++) lane_x_q[i] <= lane_x_d[i];
      end
   end

   assign o_rgb       = rgb_q;
   assign o_score     = score_q;
   assign o_lives     = lives_q;
   assign o_state     = state_q;
   assign o_collision = coll_q;

endmodule

// File: tb/tb_crossy_lane_engine.sv
// Bench for crossy_lane_engine: frame-level game model compared every cycle,
// plus directed scenarios with hand-computed pixel/score/lives expectations.
module tb_crossy_lane_engine;

   logic       clk;
   logic       rst_n;
   logic [9:0] hpos, vpos;
   logic       display_on, frame_tick, move_btn, start_btn;
   logic [2:0] rgb;
   logic [7:0] score;
   logic [1:0] lives, state;
   logic       collision;

   int n_checks = 0;
   int n_fail   = 0;

   crossy_lane_engine dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_hpos(hpos), .i_vpos(vpos),
      .i_display_on(display_on), .i_frame_tick(frame_tick),
      .i_move_btn(move_btn), .i_start_btn(start_btn),
      .o_rgb(rgb), .o_score(score), .o_lives(lives), .o_state(state),
      .o_collision(collision)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Game model: 0 idle, 1 play, 2 hit, 3 over.
   bit m_valid = 1'b0;
   int m_state, m_score, m_lives, m_scroll, m_flash, m_rgb;
   bit m_hit, m_coll;
   int m_x [4];
   bit mh [3];
   bit sh [3];

   function automatic int model_pixel(input int h, input int v, input bit de);
      bit c, ob;
      int y;
      if (!de) return 0;
      c  = (h >= 310) && (h < 340) && (v >= 400) && (v < 440);
      ob = 1'b0;
      for (int i = 0; i < 4; i++) begin
         y = (i * 120 + m_scroll) % 480;
         if ((h >= m_x[i]) && (h < m_x[i] + 50) && (v >= y) && (v < y + 30)) ob = 1'b1;
      end
      if (c && ob) return 3;
      if (ob) return 4;
      if (c && !((m_state == 2) && ((m_flash % 16) >= 8))) return 2;
      return (m_state == 3) ? 0 : 1;
   endfunction

   task automatic model_restore_lanes();
      for (int i = 0; i < 4; i++) m_x[i] = (i * 250) % 640;
   endtask

   task automatic model_step();
      int px;
      bit mv_e, st_e, new_hit;
      if (!rst_n) begin
         m_valid = 1'b1;
         m_state = 0; m_score = 0; m_lives = 3; m_scroll = 0; m_flash = 0;
         m_rgb = 0; m_hit = 1'b0; m_coll = 1'b0;
         model_restore_lanes();
         for (int i = 0; i < 3; i++) begin mh[i] = 1'b0; sh[i] = 1'b0; end
      end else if (m_valid) begin
         px      = model_pixel(int'(hpos), int'(vpos), display_on);
         mv_e    = mh[1] && !mh[2];
         st_e    = sh[1] && !sh[2];
         new_hit = frame_tick ? 1'b0 : (((m_state == 1) && (px == 3)) ? 1'b1 : m_hit);
         mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = move_btn;
         sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = start_btn;
         m_rgb  = px;
         m_coll = 1'b0;
         case (m_state)
            0: if (st_e) begin
                  m_state = 1; m_score = 0; m_lives = 3; m_scroll = 0;
                  model_restore_lanes();
               end
            1: begin
                  if (mv_e) begin
                     m_scroll = (m_scroll + 10) % 480;
                     if (m_score < 255) m_score++;
                  end
                  if (frame_tick) begin
                     for (int i = 0; i < 4; i++)
                        m_x[i] = (i % 2 == 0) ? (m_x[i] + (i % 3) + 1) % 640
                                              : (m_x[i] - ((i % 3) + 1) + 640) % 640;
                     if (m_hit) begin
                        m_state = 2; m_lives--; m_coll = 1'b1; m_flash = 0;
                     end
                  end
               end
            2: if (frame_tick) begin
                  if (m_flash == 59) begin
                     if (m_lives == 0) m_state = 3;
                     else begin
                        m_state = 1; m_scroll = 0;
                        model_restore_lanes();
                     end
                  end else m_flash++;
               end
            default: if (st_e) m_state = 0;
         endcase
         m_hit = new_hit;
      end
   endtask

   // Compare DUT against model each cycle, then advance the model for the next edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            n_checks++;
            if (rgb !== 3'(m_rgb) || score !== 8'(m_score) || lives !== 2'(m_lives) ||
                state !== 2'(m_state) || collision !== m_coll) begin
               n_fail++;
               $display("FAIL model_compare t=%0t rgb %0d/%0d score %0d/%0d lives %0d/%0d state %0d/%0d coll %0d/%0d (got/expected)",
                        $time, rgb, m_rgb, score, m_score, lives, m_lives, state, m_state, collision, m_coll);
            end
         end
         model_step();
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick();
      frame_tick = 1'b1; cyc(1);
      frame_tick = 1'b0; cyc(1);
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic press_move();
      move_btn = 1'b1; cyc(1);
      move_btn = 1'b0; cyc(1);
   endtask

   task automatic press_start();
      start_btn = 1'b1; cyc(1);
      start_btn = 1'b0; cyc(1);
      cyc(2);
   endtask

   task automatic probe(input int h, input int v, input int exp, input string name);
      hpos = 10'(h); vpos = 10'(v); display_on = 1'b1;
      cyc(1);
      display_on = 1'b0;
      check(name, int'(rgb), exp);
   endtask

   // Scroll so lane 3 sits at y=390, run lane 3 to x=300 over the chicken, then hit.
   task automatic collide(input int presses, input int adv, input int exp_lives, input string tag);
      repeat (presses) press_move();
      cyc(2);
      ticks(adv);
      probe(305, 410, 4, {tag, "_ob_only"});
      probe(325, 410, 3, {tag, "_overlap"});
      frame_tick = 1'b1; cyc(1);
      frame_tick = 1'b0;
      check({tag, "_coll_pulse"}, int'(collision), 1);
      check({tag, "_state_hit"}, int'(state), 2);
      check({tag, "_lives"}, int'(lives), exp_lives);
      cyc(1);
      check({tag, "_coll_drop"}, int'(collision), 0);
   endtask

   initial begin
      rst_n = 1'b0; hpos = '0; vpos = '0; display_on = 1'b0;
      frame_tick = 1'b0; move_btn = 1'b0; start_btn = 1'b0;
      cyc(3);
      check("rst_state", int'(state), 0);
      check("rst_score", int'(score), 0);
      check("rst_lives", int'(lives), 3);
      check("rst_rgb", int'(rgb), 0);
      check("rst_coll", int'(collision), 0);
      rst_n = 1'b1;
      cyc(2);

      press_move(); cyc(2);
      check("idle_move_ignored", int'(score), 0);
      press_start();
      check("start_play", int'(state), 1);
      probe(0, 5, 4, "lane0_at_x0");

      ticks(10);
      probe(10, 5, 4, "lane0_left_edge");
      probe(9, 5, 1, "lane0_before");
      probe(59, 29, 4, "lane0_corner");
      probe(60, 5, 1, "lane0_after");
      probe(10, 30, 1, "lane0_below");
      probe(230, 125, 4, "lane1_left_edge");
      probe(229, 125, 1, "lane1_before");
      probe(530, 245, 4, "lane2_left_edge");
      probe(529, 245, 1, "lane2_before");
      probe(100, 365, 4, "lane3_left_edge");
      probe(99, 365, 1, "lane3_before");
      probe(315, 435, 2, "chicken_play");

      repeat (3) press_move();
      cyc(2);
      check("score_3", int'(score), 3);
      probe(12, 30, 4, "scroll_lane0_top");
      probe(12, 29, 1, "scroll_lane0_above");
      probe(12, 60, 1, "scroll_lane0_below");
      probe(325, 410, 2, "chicken_no_overlap");

      collide(0, 440, 2, "hit1");
      probe(315, 435, 2, "flash0_visible");
      ticks(8);
      probe(315, 435, 1, "flash8_hidden");
      ticks(8);
      probe(315, 435, 2, "flash16_visible");
      ticks(43);
      check("hit_hold_59", int'(state), 2);
      tick();
      check("hit_to_play", int'(state), 1);
      check("hit_score_kept", int'(score), 3);
      probe(0, 5, 4, "restore_lane0");
      probe(250, 125, 4, "restore_lane1");
      probe(249, 125, 1, "restore_lane1_before");

      collide(3, 450, 1, "hit2");
      ticks(60);
      check("hit2_play", int'(state), 1);
      check("hit2_score", int'(score), 6);
      collide(3, 450, 0, "hit3");
      ticks(60);
      check("over_state", int'(state), 3);
      probe(100, 300, 0, "over_bg");
      press_move(); cyc(2);
      check("over_move_ignored", int'(score), 9);
      press_start();
      check("over_to_idle", int'(state), 0);
      press_start();
      check("restart_play", int'(state), 1);
      check("restart_lives", int'(lives), 3);
      check("restart_score", int'(score), 0);

      repeat (260) press_move();
      cyc(2);
      check("score_saturate", int'(score), 255);
      collide(31, 450, 2, "hit4");
      check("hit4_score_sat", int'(score), 255);
      ticks(5);
      hpos = 10'd315; vpos = 10'd435; display_on = 1'b1; rst_n = 1'b0;
      cyc(1);
      check("midhit_rst_rgb", int'(rgb), 0);
      check("midhit_rst_state", int'(state), 0);
      check("midhit_rst_lives", int'(lives), 3);
      check("midhit_rst_score", int'(score), 0);
      rst_n = 1'b1; display_on = 1'b0;
      cyc(2);
      check("post_rst_idle", int'(state), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
